// File: rtl/ps2_pkg.sv
// Shared PS/2 host-transmit definitions.
// States, frame size, default timing and parity helper.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    REQ,
    SHIFT,
    ACK,
    WAIT_IDLE
  } ps2_state_t;

  localparam int PS2_FRAME_BITS     = 11;
  localparam int DEF_INHIBIT_CYCLES = 5000;
  localparam int DEF_TIMEOUT_CYCLES = 750000;
  localparam int DEF_FILTER_LEN     = 8;

  function automatic logic odd_parity(
    input logic [7:0] d
  );
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// PS/2 pad conditioning: 2-FF synchronizers,
// clock glitch filter and a registered fall strobe.
module ps2_line_filter
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN = DEF_FILTER_LEN
) (
  input  logic clk50,
  input  logic reset,
  input  logic i_clk_pad,
  input  logic i_data_pad,
  output logic o_clk_filt,
  output logic o_data_sync,
  output logic o_fall
);

  localparam int CW = $clog2(FILTER_LEN + 1);

  logic [1:0]    r_clk_sync;
  logic [1:0]    r_data_sync;
  logic [CW-1:0] r_cnt;
  logic          r_filt;
  logic          r_fall;

  // Two-stage synchronizers; idle bus level is high.
  always_ff @(posedge clk50) begin
    if (reset) begin
      r_clk_sync  <= 2'b11;
      r_data_sync <= 2'b11;
    end else begin
      r_clk_sync  <= {r_clk_sync[0], i_clk_pad};
      r_data_sync <= {r_data_sync[0], i_data_pad};
    end
  end

  // Accept a new clock level after FILTER_LEN equal samples.
  always_ff @(posedge clk50) begin
    if (reset) begin
      r_cnt  <= '0;
      r_filt <= 1'b1;
      r_fall <= 1'b0;
    end else begin
      r_fall <= 1'b0;
      if (r_clk_sync[1] == r_filt) begin
        r_cnt <= '0;
      end else if (r_cnt == CW'(FILTER_LEN - 1)) begin
        r_cnt  <= '0;
        r_filt <= r_clk_sync[1];
        r_fall <= r_filt;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_clk_filt  = r_filt;
  assign o_data_sync = r_data_sync[1];
  assign o_fall      = r_fall;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request
// to send, 11-bit shift, ack check and watchdog.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = DEF_INHIBIT_CYCLES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int FILTER_LEN     = DEF_FILTER_LEN
) (
  input  logic       clk50,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_done,
  output logic       tx_error,
  output logic       busy,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe
);

  ps2_state_t  r_state;
  ps2_state_t  w_next;
  logic [7:0]  r_byte;
  logic        r_par;
  logic [12:0] r_inh_cnt;
  logic [19:0] r_wd;
  logic [3:0]  r_bit_cnt;
  logic        r_bit_oe;

  logic w_clk_filt;
  logic w_data_sync;
  logic w_fall;
  logic w_accept;
  logic w_active;
  logic w_inh_last;
  logic w_timeout;
  logic w_frame_bit;

  ps2_line_filter #(
    .FILTER_LEN (FILTER_LEN)
  ) u_filt (
    .clk50       (clk50),
    .reset       (reset),
    .i_clk_pad   (ps2_clk_in),
    .i_data_pad  (ps2_data_in),
    .o_clk_filt  (w_clk_filt),
    .o_data_sync (w_data_sync),
    .o_fall      (w_fall)
  );

  assign w_accept   = tx_valid && tx_ready;
  assign w_active   = (r_state == REQ) || (r_state == SHIFT) ||
                      (r_state == ACK) || (r_state == WAIT_IDLE);
  assign w_inh_last = (r_state == INHIBIT) &&
                      (r_inh_cnt == 13'(INHIBIT_CYCLES - 1));
  assign w_timeout  = w_active && (r_wd >= 20'(TIMEOUT_CYCLES));

  // Select the frame bit for the next device clock fall.
  always_comb begin
    w_frame_bit = 1'b1;
    unique case (1'b1)
      (r_bit_cnt < 4'd8):  w_frame_bit = r_byte[r_bit_cnt[2:0]];
      (r_bit_cnt == 4'd8): w_frame_bit = r_par;
      default:             w_frame_bit = 1'b1;
    endcase
  end

  // State register.
  always_ff @(posedge clk50) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic; the watchdog overrides every active state.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:      if (w_accept) w_next = INHIBIT;
      INHIBIT:   if (w_inh_last) w_next = REQ;
      REQ:       w_next = SHIFT;
      SHIFT:     if (w_fall && r_bit_cnt == 4'd9) w_next = ACK;
      ACK:       if (w_fall) w_next = w_data_sync ? IDLE : WAIT_IDLE;
      WAIT_IDLE: if (w_clk_filt && w_data_sync) w_next = IDLE;
      default:   w_next = IDLE;
    endcase
    if (w_timeout) w_next = IDLE;
  end

  // Byte latch, inhibit timer, watchdog and bit shifter.
  always_ff @(posedge clk50) begin
    if (reset) begin
      r_byte    <= '0;
      r_par     <= 1'b0;
      r_inh_cnt <= '0;
      r_wd      <= '0;
      r_bit_cnt <= '0;
      r_bit_oe  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_byte <= tx_data;
        r_par  <= odd_parity(tx_data);
      end
      if (r_state == INHIBIT) r_inh_cnt <= r_inh_cnt + 1'b1;
      else                    r_inh_cnt <= '0;
      if (!w_active)          r_wd <= '0;
      else if (r_wd != '1)    r_wd <= r_wd + 1'b1;
      if (r_state == REQ) begin
        r_bit_cnt <= '0;
        r_bit_oe  <= 1'b1;
      end else if (r_state == SHIFT && w_fall) begin
        r_bit_cnt <= r_bit_cnt + 1'b1;
        r_bit_oe  <= ~w_frame_bit;
      end
    end
  end

  // Line drivers, handshake and completion pulses.
  always_comb begin
    tx_ready    = (r_state == IDLE) && !reset;
    busy        = (r_state != IDLE);
    ps2_clk_oe  = (r_state == INHIBIT);
    ps2_data_oe = w_inh_last || (r_state == REQ) ||
                  ((r_state == SHIFT) && r_bit_oe);
    tx_done     = !reset && !w_timeout &&
                  (r_state == WAIT_IDLE) && w_clk_filt && w_data_sync;
    tx_error    = !reset && (w_timeout ||
                  ((r_state == ACK) && w_fall && w_data_sync));
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Randomized scoreboard bench for ps2_host_tx
// with a behavioural PS/2 device on the pads.
module tb_ps2_host_tx;

  localparam int INH  = 200;
  localparam int TO   = 6000;
  localparam int FL   = 8;
  localparam int HALF = 40;

  typedef struct packed {
    logic [1:0]  kind;
    logic [10:0] frame;
  } exp_t;

  logic       clk50 = 1'b0;
  logic       reset;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready, tx_done, tx_error, busy;
  logic       ps2_clk_in, ps2_data_in;
  logic       ps2_clk_oe, ps2_data_oe;
  logic       dev_clk, dev_data, glitch;
  logic [10:0] dev_bits;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  assign ps2_clk_in  = ~ps2_clk_oe & dev_clk & ~glitch;
  assign ps2_data_in = ~ps2_data_oe & dev_data;

  ps2_host_tx #(
    .INHIBIT_CYCLES (INH),
    .TIMEOUT_CYCLES (TO),
    .FILTER_LEN     (FL)
  ) dut (
    .clk50       (clk50),
    .reset       (reset),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .tx_done     (tx_done),
    .tx_error    (tx_error),
    .busy        (busy),
    .ps2_clk_in  (ps2_clk_in),
    .ps2_data_in (ps2_data_in),
    .ps2_clk_oe  (ps2_clk_oe),
    .ps2_data_oe (ps2_data_oe)
  );

  always #10 clk50 = ~clk50;

  task automatic chk(input bit ok, input string name,
                     input longint act, input longint req);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk50);
    #1;
  endtask

  // Start, 8 data bits LSB first, odd parity, stop.
  function automatic logic [10:0] frame_of(input logic [7:0] b);
    logic [10:0] f;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) f[i+1] = 1'((b >> i) & 1);
    f[9]  = ($countones(b) % 2 == 0);
    f[10] = 1'b1;
    return f;
  endfunction

  // Monitor: inhibit timing plus scoreboard pop on each pulse.
  initial begin
    exp_t   e;
    logic   prev_oe = 1'b0;
    int     inh_len = 0;
    int     first_d = -1;
    longint rel     = 0;
    bit     post    = 0;
    forever begin
      @(negedge clk50);
      if (post) begin
        post = 0;
        chk(!ps2_clk_oe && !ps2_data_oe, "lines_released",
            {ps2_clk_oe, ps2_data_oe}, 0);
        chk(tx_ready, "ready_after_end", tx_ready, 1);
      end
      if (ps2_clk_oe) begin
        if (ps2_data_oe && first_d < 0) first_d = inh_len;
        inh_len++;
      end else if (prev_oe) begin
        chk(inh_len == INH, "inhibit_len", inh_len, INH);
        chk(first_d == INH - 1, "start_bit_cycle", first_d, INH - 1);
        inh_len = 0;
        first_d = -1;
        rel     = 0;
      end else begin
        rel++;
      end
      prev_oe = ps2_clk_oe;
      if (tx_done || tx_error) begin
        chk(!(tx_done && tx_error), "done_err_excl",
            {tx_done, tx_error}, 2'b01);
        if (exp_q.size() == 0) begin
          chk(0, "unexpected_pulse", {tx_done, tx_error}, 0);
        end else begin
          e = exp_q.pop_front();
          chk(tx_done == (e.kind == 0), "result_kind",
              {tx_done, tx_error}, e.kind);
          if (e.kind != 2)
            chk(dev_bits == e.frame, "frame_bits", dev_bits, e.frame);
          else
            chk(rel == TO, "timeout_len", rel, TO);
          post = 1;
        end
      end
    end
  end

  // Device: waits for request-to-send, clocks nfalls bits.
  // mode 0 ack, 1 no ack, 2 silent, 3 ack with clock glitch.
  task automatic dev_run(input int mode, input int nfalls,
                         input bit drop_valid);
    int k = 0;
    dev_bits = '0;
    while (!(!ps2_clk_oe && ps2_data_oe) && k < INH + 50) begin
      tick(1);
      k++;
    end
    chk(k < INH + 50, "rts_seen", k, INH);
    if (mode == 2) return;
    tick(50);
    for (int n = 1; n <= nfalls; n++) begin
      dev_bits[n-1] = ps2_data_in;
      if (n == 11 && mode != 1) dev_data = 1'b0;
      if (n == 11 && drop_valid) tx_valid = 1'b0;
      dev_clk = 1'b0;
      tick(HALF);
      dev_clk = 1'b1;
      if (mode == 3 && n == 5) begin
        tick(10);
        glitch = 1'b1;
        tick(3);
        glitch = 1'b0;
        tick(HALF - 13);
      end else begin
        tick(HALF);
      end
    end
    dev_data = 1'b1;
  endtask

  task automatic send(input logic [7:0] b);
    int k = 0;
    while (!tx_ready && k < 100) begin
      tick(1);
      k++;
    end
    chk(tx_ready, "ready_before_send", tx_ready, 1);
    tx_data  = b;
    tx_valid = 1'b1;
    tick(1);
    tx_valid = 1'b0;
  endtask

  task automatic drain();
    int k = 0;
    while ((exp_q.size() != 0 || busy) && k < TO + 2000) begin
      tick(1);
      k++;
    end
    chk(k < TO + 2000, "drain", exp_q.size(), 0);
    tick(5);
  endtask

  task automatic xfer(input logic [7:0] b, input int mode);
    exp_t e;
    e.kind  = (mode == 1) ? 2'd1 : (mode == 2) ? 2'd2 : 2'd0;
    e.frame = frame_of(b);
    exp_q.push_back(e);
    send(b);
    dev_run(mode, 11, 1'b0);
    drain();
  endtask

  initial begin
    logic [7:0] sweep [5];
    exp_t e;
    int   nb;
    sweep = '{8'hED, 8'h00, 8'h01, 8'hFF, 8'h80};
    reset = 1'b1; tx_valid = 1'b0; tx_data = '0;
    dev_clk = 1'b1; dev_data = 1'b1; glitch = 1'b0;
    tick(3);
    @(negedge clk50);
    chk(!tx_ready, "reset_ready", tx_ready, 0);
    chk(!busy && !ps2_clk_oe && !ps2_data_oe && !tx_done && !tx_error,
        "reset_outs", {busy, ps2_clk_oe, ps2_data_oe, tx_done, tx_error}, 0);
    tick(1);
    reset = 1'b0;
    @(negedge clk50);
    chk(tx_ready, "ready_after_reset", tx_ready, 1);

    foreach (sweep[i]) xfer(sweep[i], 0);
    repeat (6) xfer(8'($urandom_range(0, 255)), 0);
    xfer(8'($urandom_range(0, 255)), 1);
    xfer(8'($urandom_range(0, 255)), 2);

    send(8'($urandom_range(0, 255)));
    dev_run(0, 3, 1'b0);
    dev_clk = 1'b0;
    tick(20);
    reset = 1'b1;
    tick(1);
    @(negedge clk50);
    chk(!ps2_clk_oe && !ps2_data_oe && !busy && !tx_done && !tx_error,
        "reset_midframe",
        {ps2_clk_oe, ps2_data_oe, busy, tx_done, tx_error}, 0);
    tick(1);
    dev_clk = 1'b1;
    reset   = 1'b0;
    tick(30);
    xfer(8'hF4, 0);

    xfer(8'($urandom_range(0, 255)), 3);

    e.kind  = 2'd0;
    e.frame = frame_of(8'hA3);
    exp_q.push_back(e);
    send(8'hA3);
    tx_data  = 8'h55;
    tx_valid = 1'b1;
    dev_run(0, 11, 1'b1);
    drain();
    nb = 0;
    repeat (40) begin
      tick(1);
      if (busy) nb++;
    end
    chk(nb == 0, "busy_valid_ignored", nb, 0);
    tx_valid = 1'b0;

    tick(10);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #3ms;
    $display("FAIL global_timeout actual=%0d required=0", 1);
    $fatal(1, "simulation time limit");
  end

endmodule
